// File: rtl/life_gen_engine_if.sv
// Scan-counter, seed-write, display-read and status bundle for life_gen_engine.
interface life_gen_engine_if #(
   parameter int XW    = 4,
   parameter int YW    = 4,
   parameter int GEN_W = 16
);
   logic             step;
   logic             scan_en;
   logic [XW-1:0]    x_count;
   logic             x_carry;
   logic [YW-1:0]    y_count;
   logic             y_carry;
   logic             wr_en;
   logic [XW-1:0]    wr_x;
   logic [YW-1:0]    wr_y;
   logic             wr_cell;
   logic [XW-1:0]    rd_x;
   logic [YW-1:0]    rd_y;
   logic             rd_cell;
   logic             busy;
   logic             done;
   logic [GEN_W-1:0] gen;

   modport master (
      output step, x_count, x_carry, y_count, y_carry,
             wr_en, wr_x, wr_y, wr_cell, rd_x, rd_y,
      input  scan_en, rd_cell, busy, done, gen
   );

   modport slave (
      input  step, x_count, x_carry, y_count, y_carry,
             wr_en, wr_x, wr_y, wr_cell, rd_x, rd_y,
      output scan_en, rd_cell, busy, done, gen
   );
endinterface

// File: rtl/life_gen_engine.sv
// Game of Life engine: one cell per clock driven by external x/y counters, commit after the last cell.
// LIFE_WRAP_EN selects a toroidal grid; otherwise off-grid neighbours are dead. rd_cell has 1-cycle latency.
module life_gen_engine #(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16,
   parameter int XW     = 4,
   parameter int YW     = 4,
   parameter int GEN_W  = 16
) (
   input logic              clk,
   input logic              resetn,
   life_gen_engine_if.slave bus
);
   localparam int CELLS = GRID_W * GRID_H;
   localparam int IW    = $clog2(CELLS);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t           state, state_nx;
   logic [CELLS-1:0] cur, nxt;
   logic [GEN_W-1:0] gen_q;
   logic             done_q, rd_q;

   int               cx, cy, nx, ny, wx, wy, rx, ry;
   logic             hit, pos_ok, wr_ok, rd_ok, self_live, next_live;
   logic [3:0]       nbr;
   logic [IW-1:0]    pos_idx, wr_idx, rd_idx;

   always_comb begin
      cx        = int'(bus.x_count[XW-1:0]);
      cy        = int'(bus.y_count[YW-1:0]);
      wx        = int'(bus.wr_x);
      wy        = int'(bus.wr_y);
      rx        = int'(bus.rd_x);
      ry        = int'(bus.rd_y);
      pos_ok    = (cx < GRID_W) && (cy < GRID_H);
      wr_ok     = (wx < GRID_W) && (wy < GRID_H);
      rd_ok     = (rx < GRID_W) && (ry < GRID_H);
      pos_idx   = IW'(cy * GRID_W + cx);
      wr_idx    = IW'(wy * GRID_W + wx);
      rd_idx    = IW'(ry * GRID_W + rx);
      self_live = pos_ok ? cur[pos_idx] : 1'b0;
      nbr       = 4'd0;
      nx        = 0;
      ny        = 0;
      hit       = 1'b0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            nx  = cx + dx;
            ny  = cy + dy;
            hit = pos_ok && !(dx == 0 && dy == 0);
`ifdef LIFE_WRAP_EN
            // coordinates are at most one step off-grid, so a single fold suffices
            if (nx < 0) nx = GRID_W - 1;
            else if (nx >= GRID_W) nx = 0;
            if (ny < 0) ny = GRID_H - 1;
            else if (ny >= GRID_H) ny = 0;
`else
            if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) hit = 1'b0;
`endif
            if (hit) nbr = nbr + 4'(cur[IW'(ny * GRID_W + nx)]);
         end
      end
      next_live = (nbr == 4'd3) || ((nbr == 4'd2) && self_live);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.step) state_nx = SCAN;
         SCAN:    if (bus.x_carry && bus.y_carry) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         cur    <= '0;
         nxt    <= '0;
         gen_q  <= '0;
         done_q <= 1'b0;
         rd_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         rd_q   <= rd_ok ? cur[rd_idx] : 1'b0;
         case (state)
            IDLE:    if (bus.wr_en && wr_ok) cur[wr_idx] <= bus.wr_cell;
            SCAN:    if (pos_ok) nxt[pos_idx] <= next_live;
            COMMIT: begin
               cur    <= nxt;
               gen_q  <= gen_q + GEN_W'(1);
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.scan_en = (state == SCAN);
   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
   assign bus.gen     = gen_q;
   assign bus.rd_cell = rd_q;
endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: whole-grid reference model compared every cycle, plus directed literal checks.
module tb_life_gen_engine;
   localparam int GW = 16, GH = 16, CELLS = GW * GH, BUSY_LEN = CELLS + 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   life_gen_engine_if #(.XW(4), .YW(4), .GEN_W(16)) bus ();
   life_gen_engine #(.GRID_W(GW), .GRID_H(GH), .XW(4), .YW(4), .GEN_W(16)) dut (
      .clk(clk), .resetn(resetn), .bus(bus));

   // small grid with a 2-bit generation counter for wrap and back-to-back timing
   life_gen_engine_if #(.XW(2), .YW(2), .GEN_W(2)) sbus ();
   life_gen_engine #(.GRID_W(3), .GRID_H(3), .XW(2), .YW(2), .GEN_W(2)) sdut (
      .clk(clk), .resetn(resetn), .bus(sbus));

   // column/row counters (MAX_VALUE = grid size, RESET_VALUE = 0)
   logic [3:0] xc, yc;
   logic [1:0] sxc, syc;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         xc <= '0; yc <= '0; sxc <= '0; syc <= '0;
      end else begin
         if (bus.scan_en) begin
            xc <= bus.x_carry ? 4'd0 : xc + 4'd1;
            if (bus.x_carry) yc <= bus.y_carry ? 4'd0 : yc + 4'd1;
         end
         if (sbus.scan_en) begin
            sxc <= sbus.x_carry ? 2'd0 : sxc + 2'd1;
            if (sbus.x_carry) syc <= sbus.y_carry ? 2'd0 : syc + 2'd1;
         end
      end
   end
   assign bus.x_count  = xc;
   assign bus.y_count  = yc;
   assign bus.x_carry  = bus.scan_en && (int'(xc) == GW - 1);
   assign bus.y_carry  = bus.x_carry && (int'(yc) == GH - 1);
   assign sbus.x_count = sxc;
   assign sbus.y_count = syc;
   assign sbus.x_carry = sbus.scan_en && (int'(sxc) == 2);
   assign sbus.y_carry = sbus.x_carry && (int'(syc) == 2);

   // reference model: grid snapshot, busy cycles remaining, generation count
   bit m_grid [GW][GH];
   int m_rem = 0;
   int m_gen = 0;
   bit m_done = 1'b0;
   bit m_rd = 1'b0;

   function automatic void next_gen();
      bit t [GW][GH];
      int n, nx, ny;
      for (int x = 0; x < GW; x++) begin
         for (int y = 0; y < GH; y++) begin
            n = 0;
            for (int dx = -1; dx <= 1; dx++) begin
               for (int dy = -1; dy <= 1; dy++) begin
                  if (dx != 0 || dy != 0) begin
                     nx = x + dx;
                     ny = y + dy;
`ifdef LIFE_WRAP_EN
                     n += int'(m_grid[(nx + GW) % GW][(ny + GH) % GH]);
`else
                     if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) n += int'(m_grid[nx][ny]);
`endif
                  end
               end
            end
            t[x][y] = (n == 3) || (n == 2 && m_grid[x][y]);
         end
      end
      m_grid = t;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         foreach (m_grid[x, y]) m_grid[x][y] = 1'b0;
         m_rem = 0; m_gen = 0; m_done = 1'b0; m_rd = 1'b0;
      end else begin
         m_rd   = m_grid[int'(bus.rd_x)][int'(bus.rd_y)];
         m_done = 1'b0;
         if (m_rem == 0) begin
            if (bus.wr_en) m_grid[int'(bus.wr_x)][int'(bus.wr_y)] = bus.wr_cell;
            if (bus.step) m_rem = BUSY_LEN;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               next_gen();
               m_gen  = (m_gen + 1) % 65536;
               m_done = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(m_rem > 0));
      chk("scan_en", 32'(bus.scan_en), 32'(m_rem > 1));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("gen", 32'(bus.gen), 32'(m_gen));
      chk("rd_cell", 32'(bus.rd_cell), 32'(m_rd));
   end

   task automatic do_reset();
      @(negedge clk); #2 resetn = 1'b0;
      @(negedge clk); #2 resetn = 1'b1;
   endtask

   task automatic write_cell(input int x, input int y, input bit v);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_x = 4'(x); bus.wr_y = 4'(y); bus.wr_cell = v;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic read_cell(input int x, input int y, output bit v);
      @(negedge clk);
      bus.rd_x = 4'(x); bus.rd_y = 4'(y);
      @(posedge clk); #1 v = bus.rd_cell;
   endtask

   task automatic count_live(output int n);
      bit v;
      n = 0;
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++) begin
            read_cell(x, y, v);
            n += int'(v);
         end
   endtask

   // step (optionally with a same-cycle seed write); returns cycles from step edge to done
   task automatic run_step(input bit with_wr, input int x, input int y, output int cyc);
      @(negedge clk);
      bus.step = 1'b1;
      if (with_wr) begin
         bus.wr_en = 1'b1; bus.wr_x = 4'(x); bus.wr_y = 4'(y); bus.wr_cell = 1'b1;
      end
      @(posedge clk); #1 bus.step = 1'b0; bus.wr_en = 1'b0;
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clk); #1 cyc++;
         if (bus.done) break;
      end
      if (cyc >= 2000) chk("done_timeout", 32'(cyc), 32'(BUSY_LEN));
   endtask

   bit v;
   int cyc, n, blen, dn, d1, d2;

   initial begin
      bus.step = 1'b0; bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_cell = 1'b0;
      bus.rd_x = '0; bus.rd_y = '0;
      sbus.step = 1'b0; sbus.wr_en = 1'b0; sbus.wr_x = '0; sbus.wr_y = '0; sbus.wr_cell = 1'b0;
      sbus.rd_x = '0; sbus.rd_y = '0;
      #22 resetn = 1'b1;
      #1;
      chk("reset_gen", 32'(bus.gen), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);

      // blinker; third cell written in the same cycle as step
      write_cell(5, 4, 1'b1);
      write_cell(5, 6, 1'b1);
      run_step(1'b1, 5, 5, cyc);
      chk("blinker_latency", 32'(cyc), 32'd257);
      chk("blinker_gen1", 32'(bus.gen), 32'd1);
      read_cell(4, 5, v); chk("blinker_4_5", 32'(v), 32'd1);
      read_cell(6, 5, v); chk("blinker_6_5", 32'(v), 32'd1);
      read_cell(5, 4, v); chk("blinker_5_4_dead", 32'(v), 32'd0);
      count_live(n); chk("blinker_count", 32'(n), 32'd3);
      run_step(1'b0, 0, 0, cyc);
      chk("blinker_gen2", 32'(bus.gen), 32'd2);
      read_cell(5, 6, v); chk("blinker_back_5_6", 32'(v), 32'd1);
      read_cell(4, 5, v); chk("blinker_back_4_5", 32'(v), 32'd0);

      // reset at scan cycle 100
      @(negedge clk); bus.step = 1'b1;
      @(posedge clk); #1 bus.step = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk); #2 resetn = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_gen", 32'(bus.gen), 32'd0);
      chk("rst_scan_en", 32'(bus.scan_en), 32'd0);
      chk("rst_counters", 32'({xc, yc}), 32'd0);
      @(negedge clk); #2 resetn = 1'b1;
      count_live(n); chk("rst_cleared", 32'(n), 32'd0);
      run_step(1'b0, 0, 0, cyc);
      chk("rst_next_latency", 32'(cyc), 32'd257);
      chk("rst_next_gen", 32'(bus.gen), 32'd1);

      // block still life
      do_reset();
      write_cell(2, 2, 1'b1); write_cell(3, 2, 1'b1);
      write_cell(2, 3, 1'b1); write_cell(3, 3, 1'b1);
      repeat (3) run_step(1'b0, 0, 0, cyc);
      chk("block_gen", 32'(bus.gen), 32'd3);
      read_cell(3, 3, v); chk("block_3_3", 32'(v), 32'd1);
      count_live(n); chk("block_count", 32'(n), 32'd4);

      // corner cells
      do_reset();
      write_cell(0, 0, 1'b1); write_cell(15, 0, 1'b1); write_cell(0, 15, 1'b1);
      run_step(1'b0, 0, 0, cyc);
      read_cell(15, 15, v);
      count_live(n);
`ifdef LIFE_WRAP_EN
      chk("wrap_15_15", 32'(v), 32'd1);
      chk("wrap_count", 32'(n), 32'd4);
`else
      chk("edge_15_15", 32'(v), 32'd0);
      chk("edge_count", 32'(n), 32'd0);
`endif

      // step and write mid-scan are ignored
      do_reset();
      @(negedge clk); bus.step = 1'b1;
      @(posedge clk); #1 bus.step = 1'b0;
      blen = int'(bus.busy);
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clk); #1 cyc++;
         bus.step = 1'b0; bus.wr_en = 1'b0;
         if (cyc == 50) begin
            bus.step = 1'b1; bus.wr_en = 1'b1; bus.wr_x = 4'd7; bus.wr_y = 4'd7; bus.wr_cell = 1'b1;
         end
         if (bus.done) break;
         blen += int'(bus.busy);
      end
      bus.step = 1'b0; bus.wr_en = 1'b0;
      chk("ignored_busy_len", 32'(blen), 32'd257);
      repeat (3) @(posedge clk);
      #1 chk("ignored_no_rescan", 32'(bus.busy), 32'd0);
      read_cell(7, 7, v); chk("ignored_write", 32'(v), 32'd0);

      // small grid: step held high, 5 generations with GEN_W=2
      do_reset();
      @(negedge clk); sbus.step = 1'b1;
      dn = 0; d1 = 0; d2 = 0; cyc = 0;
      while (dn < 5 && cyc < 500) begin
         @(posedge clk); #1 cyc++;
         if (sbus.done) begin
            dn++;
            if (dn == 1) d1 = cyc;
            if (dn == 2) d2 = cyc;
         end
      end
      sbus.step = 1'b0;
      chk("b2b_done_count", 32'(dn), 32'd5);
      chk("b2b_period", 32'(d2 - d1), 32'd11);
      chk("gen_wrap", 32'(sbus.gen), 32'd1);
      repeat (3) @(posedge clk);
      #1 chk("b2b_stopped", 32'(sbus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
